// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder operand loader
//
// Purpose: state encoding, default widths/latency and small sizing helpers
//          used by adder_operand_loader.
// Ports:   none (package)

package adder_pkg;

   localparam int DEF_WORD_W  = 32;
   localparam int DEF_OP_W    = 128;
   localparam int DEF_ADD_LAT = 1;

   typedef enum logic [2:0] {
      S_LOAD_A,
      S_LOAD_B,
      S_ISSUE,
      S_WAIT,
      S_DRAIN
   } state_t;

   function automatic int nwords(input int op_w, input int word_w);
      return op_w / word_w;
   endfunction

   // Counter width that never collapses to zero bits when the count range is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - operand assembler and result drainer for a wide adder
//
// Purpose: collects NWORDS words of A then NWORDS words of B from the input
//          stream, pulses add_en once, captures add_sum/add_cout ADD_LAT cycles
//          later and returns the sum as NWORDS stream words, LS word first.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data  operand word stream (A words then B words)
//   add_a, add_b, add_en       operands and one-cycle enable to the adder
//   add_sum, add_cout          adder result, valid ADD_LAT cycles after add_en
//   res_valid/res_ready        result word stream handshake
//   res_data, res_last         result word and final-word marker
//   res_cout                   captured carry-out, held until the next capture

module adder_operand_loader
   import adder_pkg::*;
#(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic [OP_W-1:0]   add_a,
   output logic [OP_W-1:0]   add_b,
   output logic              add_en,
   input  logic [OP_W-1:0]   add_sum,
   input  logic              add_cout,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [WORD_W-1:0] res_data,
   output logic              res_last,
   output logic              res_cout
);

   localparam int NWORDS = nwords(OP_W, WORD_W);
   localparam int CNT_W  = cnt_width(NWORDS);
   localparam int LAT_W  = cnt_width(ADD_LAT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT - 1);

   generate
      if ((OP_W % WORD_W) != 0 || ADD_LAT < 1) begin : g_bad_params
         $error("adder_operand_loader: OP_W must be a multiple of WORD_W and ADD_LAT >= 1");
      end
   endgenerate

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [LAT_W-1:0]  r_lat;
   logic [OP_W-1:0]   r_add_a;
   logic [OP_W-1:0]   r_add_b;
   logic [OP_W-1:0]   r_result;
   logic              r_res_cout;

   logic              w_in_hs;
   logic              w_res_hs;
   logic              w_cnt_last;
   logic              w_lat_done;

   assign w_in_hs    = in_valid & in_ready;
   assign w_res_hs   = res_valid & res_ready;
   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_lat_done = (r_lat == LAT_LAST);

   assign add_a    = r_add_a;
   assign add_b    = r_add_b;
   assign res_cout = r_res_cout;

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      add_en       = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;
      res_last     = 1'b0;
      case (r_state)
         S_LOAD_A: begin
            in_ready = 1'b1;
            if (w_in_hs && w_cnt_last) w_next_state = S_LOAD_B;
         end
         S_LOAD_B: begin
            in_ready = 1'b1;
            if (w_in_hs && w_cnt_last) w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            add_en       = 1'b1;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_lat_done) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            res_valid = 1'b1;
            res_data  = r_result[int'(r_cnt)*WORD_W +: WORD_W];
            res_last  = w_cnt_last;
            if (w_res_hs && w_cnt_last) w_next_state = S_LOAD_A;
         end
         default: w_next_state = S_LOAD_A;
      endcase
   end

   // The word counter is shared by both load phases and the drain phase;
   // each phase ends with it wrapped back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_LOAD_A;
         r_cnt      <= '0;
         r_lat      <= '0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_result   <= '0;
         r_res_cout <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_LOAD_A: begin
               if (w_in_hs) begin
                  r_add_a[int'(r_cnt)*WORD_W +: WORD_W] <= in_data;
                  r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
               end
            end
            S_LOAD_B: begin
               if (w_in_hs) begin
                  r_add_b[int'(r_cnt)*WORD_W +: WORD_W] <= in_data;
                  r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
               end
            end
            S_ISSUE: begin
               r_lat <= '0;
            end
            S_WAIT: begin
               if (w_lat_done) begin
                  r_result   <= add_sum;
                  r_res_cout <= add_cout;
               end else begin
                  r_lat <= r_lat + LAT_W'(1);
               end
            end
            S_DRAIN: begin
               if (w_res_hs) r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule
